// File: rtl/piso_pkg.sv
// Shared state encoding and sizing helpers for the piso_tx_5bits serial transmitter.
package piso_pkg;

  localparam int PISO_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } piso_state_e;

  function automatic int piso_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit left-shifting register with load/shift enables; exposes the MSB and,
// when PIS_TX_PARITY_EN is defined, the even parity of the most recently loaded word.
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
`ifdef PIS_TX_PARITY_EN
  output logic             parity,
`endif
  output logic             msb
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Load takes priority over shift; zeros enter from the LSB side.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_d = shreg_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= {WIDTH{1'b0}};
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[WIDTH-1];

`ifdef PIS_TX_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  logic parity_q;
  logic parity_d;

  // Parity is captured at load time because the shift register is consumed while sending.
  always_comb begin
    if (load) begin
      parity_d = even_parity(din);
    end else begin
      parity_d = parity_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: rtl/piso_tx_5bits.sv
// Parallel-in serial-out transmitter, MSB first, valid/ready input handshake.
// Optional trailing even-parity bit is compiled in with the PIS_TX_PARITY_EN macro.
module piso_tx_5bits
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = piso_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  piso_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_s, shift_s, msb_s;
  logic          sout_q, sout_d;
  logic          sout_valid_q, sout_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          din_ready_q, din_ready_d;
`ifdef PIS_TX_PARITY_EN
  logic          parity_s;
`endif

  piso_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .shift  (shift_s),
    .din    (din),
`ifdef PIS_TX_PARITY_EN
    .parity (parity_s),
`endif
    .msb    (msb_s)
  );

  // Outputs are registered one stage behind the state, so each bit appears the cycle after its state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    din_ready_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (din_valid && din_ready_q) begin
          load_s  = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = ST_SHIFT;
        end else begin
          din_ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        sout_d       = msb_s;
        sout_valid_d = 1'b1;
        busy_d       = 1'b1;
        shift_s      = 1'b1;
        if (cnt_q == CNT_LAST) begin
`ifdef PIS_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_DONE;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PIS_TX_PARITY_EN
      ST_PARITY: begin
        sout_d       = parity_s;
        sout_valid_d = 1'b1;
        busy_d       = 1'b1;
        state_d      = ST_DONE;
      end
`endif
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      din_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      din_ready_q  <= din_ready_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign din_ready  = din_ready_q;

endmodule
